blink_period_ctrl: RTL
======================

# blink_period_ctrl

Upstream control stage for the LED blinker. It debounces two raw push-buttons, "faster" and "slower", and steps a saturating blink period between `MIN_PERIOD` and `MAX_PERIOD`. It drives the blinker's 32-bit `period` input and issues a one-cycle `reload` pulse. The blinker samples `period` only while its reset is asserted, so `reload` is OR'd into the blinker's reset.

## Interface
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a button level change.
- `MIN_PERIOD`, 1: lowest period produced; must match the blinker's `MIN_PERIOD`.
- `MAX_PERIOD`, 1000: highest period produced; must match the blinker's `MAX_PERIOD`.
- `DEFAULT_PERIOD`, 1: period after reset.
- `STEP`, 1: period increment/decrement per accepted press.

- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `btn_slower` in 1: raw button, asynchronous to `clk`, active-high; a press increases the period.
- `btn_faster` in 1: raw button, asynchronous to `clk`, active-high; a press decreases the period.
- `period` out 32: current period, registered, unsigned.
- `reload` out 1: registered one-cycle pulse; high for exactly the cycle after `period` changes.

## Operation
- **Elaboration checks** (`$fatal`):
  - `MIN_PERIOD` ≥ 1.
  - `MIN_PERIOD` ≤ `MAX_PERIOD` ≤ 2^31-1.
  - `DEFAULT_PERIOD` lies within [`MIN_PERIOD`, `MAX_PERIOD`].
  - `STEP` ≥ 1.
  - `DEBOUNCE_CYCLES` ≥ 1.
- **Synchronizer:** each button passes through a 2-flop synchronizer (`s1` → `s2`).
- **Debouncer, per button:**
  - State: stable level `deb` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == deb`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
  - Any single-cycle return to the `deb` level restarts the count.
- **Press event:** asserted at the edge where `deb` goes 0→1. Releases (1→0) generate no event. A held button produces exactly one event; there is no auto-repeat.
- **Update rules** (all arithmetic in 33 bits to avoid overflow; evaluated at the same edge as the event):
  - Slower event only: `period` ← min(`period`+`STEP`, `MAX_PERIOD`).
  - Faster event only: `period` ← (`period` < `MIN_PERIOD`+`STEP`) ? `MIN_PERIOD` : `period`-`STEP`.
  - Both events at the same edge: no change, no `reload`.
  - Computed value equals current `period` (saturated): no `reload`.
  - Otherwise: `reload` ← 1 at the same edge that `period` updates; `reload` ← 0 at the following edge.
- `period` is held constant while `reload` is high and always until the next accepted event.
- **Reset** (asynchronous, immediate):
  - `period` = `DEFAULT_PERIOD`, `reload` = 0.
  - Synchronizer flops, `deb`, and `cnt` are all 0.
  - A press in progress is discarded. A button held through reset release is accepted after the full debounce window (edge 2+`DEBOUNCE_CYCLES`).

## Timing
- Edge 1 is the first rising edge sampling a new raw level; the level is held.
- `s2` updates at edge 2.
- `deb` flips, `period` updates, and `reload` rises at edge 2+`DEBOUNCE_CYCLES`.
- `reload` falls at edge 3+`DEBOUNCE_CYCLES`.
- Press-to-`period` latency is therefore `DEBOUNCE_CYCLES`+2 cycles.
- Minimum spacing between two accepted presses of the same button: 2·`DEBOUNCE_CYCLES` cycles (release window plus press window).
- The two buttons debounce independently. Their events are combined only at the update stage.
- `reload` is never high on two consecutive cycles.

## Test plan
- **Reset values** (`DEFAULT_PERIOD`=5): assert reset mid-cycle → `period`=5 and `reload`=0 immediately (asynchronous).
- **Debounce latency** (`DEBOUNCE_CYCLES`=4, `STEP`=2, `period`=5): raise `btn_slower` before edge 1 and hold 20 cycles → `period`=7 and `reload`=1 after edge 6; `reload`=0 after edge 7; no further change while held.
- **Bounce rejection** (`DEBOUNCE_CYCLES`=4): toggle `btn_faster` 1,1,1,0,1,1,1,0 per cycle, then hold 0 → `period` never changes, `reload` never asserts.
- **Saturation** (`MIN_PERIOD`=1, `MAX_PERIOD`=10, `STEP`=4):
  - From 9, slower press → 10 with `reload`; second slower press → 10, no `reload`.
  - From 3, faster press → 1 with `reload`; second faster press → 1, no `reload`.
- **Simultaneous presses:** raise both buttons in the same cycle and hold → no `period` change, no `reload`. Release and press only `btn_slower` → normal increment.
- **Reset mid-debounce** (`DEBOUNCE_CYCLES`=8): press `btn_slower`, assert reset at edge 5, release reset while still holding → increment occurs at edge 2+8 counted from the first edge after reset release, with a single `reload`.

Source files
------------

// File: rtl/blink_period_ctrl_if.sv
// Button inputs and period/reload outputs of the blinker period controller.
interface blink_period_ctrl_if;
   logic        btn_slower;
   logic        btn_faster;
   logic [31:0] period;
   logic        reload;

   // Controller side: samples the raw buttons, drives period/reload.
   modport slave (
      input  btn_slower,
      input  btn_faster,
      output period,
      output reload
   );

   // Stimulus side: drives the raw buttons, observes period/reload.
   modport master (
      output btn_slower,
      output btn_faster,
      input  period,
      input  reload
   );
endinterface

// File: rtl/blink_period_ctrl.sv
// Debounces the faster/slower buttons and steps a saturating blink period,
// pulsing reload for one cycle whenever the period changes.
module blink_period_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned MIN_PERIOD      = 1,
   parameter int unsigned MAX_PERIOD      = 1000,
   parameter int unsigned DEFAULT_PERIOD  = 1,
   parameter int unsigned STEP            = 1
) (
   input  logic                clk,
   input  logic                reset,
   blink_period_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [32:0] MIN_P  = 33'(MIN_PERIOD);
   localparam logic [32:0] MAX_P  = 33'(MAX_PERIOD);
   localparam logic [32:0] STEP_P = 33'(STEP);
   localparam logic [31:0] DEF_P  = 32'(DEFAULT_PERIOD);

   // Parameter sanity checks at elaboration.
   if (MIN_PERIOD < 1) begin : g_chk_min
      $fatal(1, "MIN_PERIOD must be >= 1");
   end
   if (MAX_PERIOD < MIN_PERIOD || MAX_PERIOD > 32'h7FFF_FFFF) begin : g_chk_max
      $fatal(1, "MAX_PERIOD must lie in [MIN_PERIOD, 2^31-1]");
   end
   if (DEFAULT_PERIOD < MIN_PERIOD || DEFAULT_PERIOD > MAX_PERIOD) begin : g_chk_def
      $fatal(1, "DEFAULT_PERIOD must lie in [MIN_PERIOD, MAX_PERIOD]");
   end
   if (STEP < 1) begin : g_chk_step
      $fatal(1, "STEP must be >= 1");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
      $fatal(1, "DEBOUNCE_CYCLES must be >= 1");
   end

   // Bit 0 = slower, bit 1 = faster throughout.
   logic [1:0]            btn_raw;
   logic [1:0]            s1_d, s1_q;
   logic [1:0]            s2_d, s2_q;
   logic [1:0]            deb_d, deb_q;
   logic [1:0][CNT_W-1:0] cnt_d, cnt_q;
   logic [1:0]            press_c;
   logic [32:0]           cur_c, inc_c, slower_c, faster_c, next_c;
   logic [31:0]           period_d, period_q;
   logic                  reload_d, reload_q;

   assign btn_raw = {bus.btn_faster, bus.btn_slower};

   // Synchronizers and per-button debounce counters; press on accepted 0->1.
   always_comb begin
      s1_d    = btn_raw;
      s2_d    = s1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      press_c = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i]   = s2_q[i];
            cnt_d[i]   = '0;
            press_c[i] = s2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Saturating period update in 33 bits; both buttons at once cancel out.
   // An event landing in the reload cycle is dropped so period stays put
   // and reload can never stretch to two cycles.
   always_comb begin
      cur_c    = {1'b0, period_q};
      inc_c    = cur_c + STEP_P;
      slower_c = (inc_c > MAX_P) ? MAX_P : inc_c;
      faster_c = (cur_c < MIN_P + STEP_P) ? MIN_P : cur_c - STEP_P;
      unique case (press_c)
         2'b01:   next_c = slower_c;
         2'b10:   next_c = faster_c;
         default: next_c = cur_c;
      endcase
      period_d = period_q;
      reload_d = 1'b0;
      if (!reload_q && next_c != cur_c) begin
         period_d = next_c[31:0];
         reload_d = 1'b1;
      end
   end

   // State registers, asynchronously reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         deb_q    <= '0;
         cnt_q    <= '0;
         period_q <= DEF_P;
         reload_q <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         reload_q <= reload_d;
      end
   end

   assign bus.period = period_q;
   assign bus.reload = reload_q;

endmodule
